rr_arbiter16: RTL and testbench

Round-robin arbiter sharing one 16-way resource among 16 requesters. Selects one requester per grant, outputs its 4-bit index and enable in the form consumed by the 4:16 decoder, and provides the matching one-hot grant vector directly. Sits between the requester bank and the decoder-driven select lines of the shared resource, and sequences ownership (grant, hold, release).

---
 rtl/rr_arbiter16_if.sv | 39 +++
 rtl/rr_arbiter16.sv | 136 +++++++++++++
 tb/tb_rr_arbiter16.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rr_arbiter16_if.sv
// rr_arbiter16_if: request/grant bundle between the requester bank and the
// round-robin arbiter.
//   req       : 16-bit request vector, bit i = requester i wants the resource
//   done      : current owner releases the resource
//   grant_en  : a grant is active (decoder enable)
//   grant_idx : 4-bit owner index (decoder select), qualify with grant_en
//   grant     : one-hot grant vector
//   busy      : mirrors grant_en
//   timeout   : one-cycle pulse when a grant is revoked by the hold limit
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter16_if;
  logic [15:0] req;
  logic        done;
  logic        grant_en;
  logic [3:0]  grant_idx;
  logic [15:0] grant;
  logic        busy;
  logic        timeout;

  modport master (
    output req,
    output done,
    input  grant_en,
    input  grant_idx,
    input  grant,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant_en,
    output grant_idx,
    output grant,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin arbiter sharing one resource among 16 requesters.
// Issues one grant at a time (index + enable for a 4:16 decoder, plus a
// one-hot vector), holds it until done, the owner's request drops, or
// (optionally) a hold limit expires, then spends one IDLE cycle before
// re-arbitrating so decoder outputs are guaranteed to go low between owners.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rr_arbiter16_if.slave (req/done in, grant_en/grant_idx/grant/busy/timeout out)
// Parameters:
//   MAX_HOLD : grant hold limit in cycles (1..255), only used with ARB_TIMEOUT_EN.
// Optional feature macro: ARB_TIMEOUT_EN enables the hold limit and timeout pulse;
// when undefined, grants are unbounded and timeout is tied to 0.
// All outputs come straight from flops; no combinational path from req/done.
module rr_arbiter16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter16_if.slave bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_check
    $error("rr_arbiter16: MAX_HOLD must be in 1..255");
  end

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  state_e      r_state;
  logic [3:0]  r_ptr;
  logic [3:0]  r_idx;
  logic [15:0] r_grant;
  logic        r_grant_en;

  logic        w_any;
  logic [3:0]  w_sel;
  logic [3:0]  w_cand;
  logic        w_hold_hit;
  logic        w_release;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic [7:0]  r_hcnt;
  logic        r_timeout;

  assign w_hold_hit = (r_hcnt == HoldLast);
`else
  assign w_hold_hit = 1'b0;
`endif

  // Search upward from r_ptr with wrap. Scanning offsets high-to-low lets the
  // smallest offset (closest to the pointer) win by being assigned last.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = r_ptr;
    w_cand = r_ptr;
    for (int i = 15; i >= 0; i--) begin
      w_cand = r_ptr + 4'(i);
      if (bus.req[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  assign w_release = bus.done | ~bus.req[r_idx] | w_hold_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_ptr      <= 4'd0;
      r_idx      <= 4'd0;
      r_grant    <= 16'h0000;
      r_grant_en <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hcnt     <= 8'd0;
      r_timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_state    <= StGrant;
            r_idx      <= w_sel;
            r_ptr      <= w_sel + 4'd1;
            r_grant    <= 16'h0001 << w_sel;
            r_grant_en <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            r_hcnt     <= 8'd0;
`endif
          end
        end
        StGrant: begin
          if (w_release) begin
            // grant_idx keeps its value; consumers qualify it with grant_en.
            r_state    <= StIdle;
            r_grant    <= 16'h0000;
            r_grant_en <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            // A done coinciding with the limit is an ordinary release.
            r_timeout  <= w_hold_hit & ~bus.done;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_hcnt != 8'hff) begin
            r_hcnt <= r_hcnt + 8'd1;
          end
`endif
        end
        default: begin
          r_state    <= StIdle;
          r_grant    <= 16'h0000;
          r_grant_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_en  = r_grant_en;
  assign bus.busy      = r_grant_en;
  assign bus.grant_idx = r_idx;
  assign bus.grant     = r_grant;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = r_timeout;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: table-driven directed bench for rr_arbiter16. Each row
// optionally resets, drives req/done for one clock, and compares the outputs
// half a cycle after the edge. Mid-grant asynchronous reset is hand-written.
module tb_rr_arbiter16;

`ifdef ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter16_if bus ();

  rr_arbiter16 #(
    .MAX_HOLD(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit          rst;
    logic [15:0] req;
    logic        done;
    logic        en;
    logic [3:0]  idx;
    logic [15:0] gnt;
    logic        to;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, got, exp);
    end
  endtask

  task automatic check_outs(input int row, input logic en, input logic [3:0] idx,
                            input logic [15:0] gnt, input logic to);
    check("grant_en", row, 32'(bus.grant_en), 32'(en));
    check("busy", row, 32'(bus.busy), 32'(en));
    check("grant_idx", row, 32'(bus.grant_idx), 32'(idx));
    check("grant", row, 32'(bus.grant), 32'(gnt));
    check("timeout", row, 32'(bus.timeout), 32'(to));
  endtask

  task automatic add(input bit rst, input logic [15:0] req, input logic done,
                     input logic en, input logic [3:0] idx, input logic [15:0] gnt,
                     input logic to);
    vec_t v;
    v.rst  = rst;
    v.req  = req;
    v.done = done;
    v.en   = en;
    v.idx  = idx;
    v.gnt  = gnt;
    v.to   = to;
    vecs.push_back(v);
  endtask

  // Pulse reset in the low phase, away from the rising edge.
  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req  = 16'h0000;
    bus.done = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Idle: no requests for 10 cycles.
    for (int i = 0; i < 10; i++) add(0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0);
    // Single requester 0, done after 3 grant cycles.
    for (int i = 0; i < 3; i++) add(0, 16'h0001, 0, 1, 4'd0, 16'h0001, 0);
    add(0, 16'h0001, 1, 0, 4'd0, 16'h0000, 0);
    add(0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0);
    // Fairness from ptr=0: 0, 5, 10, 15, 0 with one IDLE between grants.
    add(1, 16'h8421, 1, 1, 4'd0,  16'h0001, 0);
    add(0, 16'h8421, 1, 0, 4'd0,  16'h0000, 0);
    add(0, 16'h8421, 1, 1, 4'd5,  16'h0020, 0);
    add(0, 16'h8421, 1, 0, 4'd5,  16'h0000, 0);
    add(0, 16'h8421, 1, 1, 4'd10, 16'h0400, 0);
    add(0, 16'h8421, 1, 0, 4'd10, 16'h0000, 0);
    add(0, 16'h8421, 1, 1, 4'd15, 16'h8000, 0);
    add(0, 16'h8421, 1, 0, 4'd15, 16'h0000, 0);
    add(0, 16'h8421, 1, 1, 4'd0,  16'h0001, 0);
    add(0, 16'h0000, 0, 0, 4'd0,  16'h0000, 0);
    // Wrap: grant 14 sets ptr=15; owner drops req, then 8001 -> 15, then 0.
    add(0, 16'h4000, 0, 1, 4'd14, 16'h4000, 0);
    add(0, 16'h8001, 0, 0, 4'd14, 16'h0000, 0);
    add(0, 16'h8001, 0, 1, 4'd15, 16'h8000, 0);
    add(0, 16'h8001, 1, 0, 4'd15, 16'h0000, 0);
    add(0, 16'h8001, 0, 1, 4'd0,  16'h0001, 0);
    add(0, 16'h0000, 0, 0, 4'd0,  16'h0000, 0);
    // Hold limit (MAX_HOLD=4): with the feature, 4 grant cycles, one IDLE with
    // timeout, then re-grant; without it the grant simply continues.
    add(1, 16'h0010, 0, 1, 4'd4, 16'h0010, 0);
    for (int i = 0; i < 3; i++) add(0, 16'h0010, 0, 1, 4'd4, 16'h0010, 0);
    add(0, 16'h0010, 0, !ToEn, 4'd4, ToEn ? 16'h0000 : 16'h0010, ToEn);
    add(0, 16'h0010, 0, 1, 4'd4, 16'h0010, 0);
    add(0, 16'h0000, 0, 0, 4'd4, 16'h0000, 0);

    // Reset state.
    bus.req  = 16'h0000;
    bus.done = 1'b0;
    #12;
    check_outs(-1, 0, 4'd0, 16'h0000, 0);
    rst_n = 1'b1;

    foreach (vecs[r]) begin
      if (vecs[r].rst) apply_reset();
      bus.req  = vecs[r].req;
      bus.done = vecs[r].done;
      @(posedge clk);
      @(negedge clk);
      check_outs(r, vecs[r].en, vecs[r].idx, vecs[r].gnt, vecs[r].to);
    end

    // Mid-grant asynchronous reset: outputs clear with no clock edge.
    apply_reset();
    bus.req = 16'h0200;
    @(posedge clk);
    @(negedge clk);
    check_outs(100, 1, 4'd9, 16'h0200, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs(101, 0, 4'd0, 16'h0000, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outs(102, 1, 4'd9, 16'h0200, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
